basic_cpu_ctrl: RTL
===================

Name: basic_cpu_ctrl

Overview:
- Control unit for the basic-computer datapath.
- Runs a fetch/decode/indirect/execute sequence for every 16-bit instruction and drives the datapath control strobes (o_read ... o_is_idle).
- Paces every memory access with a request/acknowledge handshake, bounded by a timeout.
- Sits between the instruction register output and the datapath control inputs. One instance per CPU.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles a read or write request waits for mem_ack before aborting; legal range 1..255.
- SC_W, 3: width of the o_sc step-counter output.

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  leave IDLE and begin fetching at the current PC
- ir  input  16  instruction register from the datapath; [15]=I, [14:12]=opcode, [11:0]=address/ref bits; must be valid from the DECODE cycle
- mem_ack  input  1  memory completes the pending read/write this cycle
- o_read, o_write, o_we  output  1 each  memory strobes; o_we = o_write
- o_fetch  output  1  IR <- M[AR], PC++
- o_reg_ref, o_clr_sc, o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac  output  1 each  register-reference strobes
- o_mem_ref, o_ind_addr, o_add, o_load, o_store, o_branch, o_isz  output  1 each  memory-reference strobes
- o_is_idle  output  1  controller is in IDLE
- o_sc  output  SC_W  current T-step (0 = T0), saturating at 7
- o_bus_err  output  1  one-cycle pulse on a handshake timeout

Behaviour:
- Outputs are a Moore decode of the registered state plus the latched instruction ir_q. Reset (async) forces: state=IDLE, ir_q=0, o_sc=0, timeout counter=0; every output 0 except o_is_idle=1. Reset mid-access drops o_read/o_write the same instant.
- States and transitions:
  - IDLE: start=1 -> FETCH_AR.
  - FETCH_AR (T0): one cycle, AR <- PC, no strobes -> FETCH_IR.
  - FETCH_IR (T1): o_read=1, o_fetch=1, held until mem_ack; mem_ack=1 -> DECODE.
  - DECODE (T2): one cycle, latch ir_q <- ir.
    - opcode 7 with I=0 -> REG.
    - I=1 with opcode != 7 -> INDIRECT.
    - otherwise -> EXEC.
  - INDIRECT: o_mem_ref=1, o_ind_addr=1, o_read=1 until mem_ack -> EXEC.
  - REG: one cycle with o_reg_ref=1 and o_clr_sc=1. Bit strobes: ir_q[11]=o_clr_ac, [10]=o_clr_e, [9]=o_comp_ac, [7]=o_cir_r, [6]=o_cir_l, [5]=o_inc_ac. Several bits may be set together; all fire in the same cycle. Then: ir_q[0] (HLT) -> IDLE, else -> FETCH_AR.
  - EXEC, by opcode; o_mem_ref=1 in every EXEC cycle:
    - 1 ADD: read (o_add, o_read until ack), then one cycle o_add + o_load_ac + o_clr_sc.
    - 2 LDA: read (o_load, o_read), then one cycle o_load + o_load_ac + o_clr_sc.
    - 3 STA: o_store + o_write + o_we until ack; the ack cycle also asserts o_clr_sc.
    - 4 BUN: one cycle o_branch + o_clr_sc.
    - 6 ISZ: read (o_isz, o_read), then one cycle o_isz (DR++), then o_isz + o_write + o_we until ack, with o_clr_sc in the ack cycle.
    - 0, 5, and opcode 7 with I=1: one cycle o_clr_sc, no effect (NOP).
- Every instruction ends in FETCH_AR, except HLT, which ends in IDLE.
- Handshake:
  - A request holds its strobe level until the cycle mem_ack is sampled 1.
  - mem_ack in the first request cycle gives a one-cycle access.
  - mem_ack outside a request is ignored.
- Timeout:
  - The counter clears on entry to each request and increments every waiting cycle.
  - Reaching MEM_TIMEOUT without ack: drop the request, pulse o_bus_err for 1 cycle, go to IDLE.
  - If ack and timeout coincide, ack wins.
- o_sc: 0 in FETCH_AR; increments once per state advance and once per wait cycle; saturates at 7; cleared on entry to FETCH_AR or IDLE.
- start asserted outside IDLE is ignored.

Optional Feature:
- CTRL_ILLEGAL_TRAP_EN.
- Defined: in REG, any set ref bit among [8] and [4:1] traps. Also trapped: opcode 0, opcode 5, and opcode 7 with I=1. A trap asserts no strobes, pulses o_illegal (extra 1-bit output) for one cycle, and goes to IDLE.
- Undefined: those encodings execute as NOP as described above, and the o_illegal port is absent.

Test Plan:
- Reset, then start=1 with mem_ack tied 1 and ir=0x7800 (CLA) -> FETCH_AR, FETCH_IR, DECODE, then REG with o_reg_ref=1, o_clr_ac=1, o_clr_sc=1 in cycle 4; back at T0 in cycle 5.
- ir=0x1123 (ADD, direct), mem_ack delayed 3 cycles in each access -> o_read held 3 cycles in FETCH_IR and in the EXEC read; o_add+o_load_ac+o_clr_sc for exactly 1 cycle; o_sc reaches 7 (saturated).
- ir=0xB040 (STA, indirect), mem_ack immediate -> INDIRECT cycle with o_ind_addr=1, o_read=1; next cycle o_store=o_write=o_we=o_clr_sc=1; o_read=0 throughout that cycle.
- ir=0x6010 (ISZ) -> read, then o_isz-only cycle, then write; o_clr_sc coincides with the write ack; total 7 cycles with immediate ack.
- mem_ack never asserted during fetch, MEM_TIMEOUT=15 -> o_read high 15 cycles, o_bus_err pulse, then o_is_idle=1; rst_n=0 asserted mid-wait instead -> all strobes 0 immediately, o_is_idle=1.
- ir=0x7001 (HLT) -> one REG cycle, then IDLE; start during execution ignored; new start resumes fetch.

Source files
------------

// File: rtl/basic_cpu_ctrl.sv
// basic_cpu_ctrl: control unit for the basic-computer datapath.
// It sequences fetch, decode, indirect and execute for each 16-bit
// instruction and drives the datapath control strobes. Every memory access
// uses a request/acknowledge handshake that aborts after MEM_TIMEOUT cycles.
// Optional feature macro CTRL_ILLEGAL_TRAP_EN: when defined, undefined
// encodings trap to IDLE and pulse the extra o_illegal output. When it is
// not defined, those encodings execute as NOPs.
module basic_cpu_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int SC_W        = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [15:0]     ir,
    input  logic            mem_ack,
    output logic            o_read,
    output logic            o_write,
    output logic            o_we,
    output logic            o_fetch,
    output logic            o_reg_ref,
    output logic            o_clr_sc,
    output logic            o_clr_ac,
    output logic            o_clr_e,
    output logic            o_comp_ac,
    output logic            o_load_ac,
    output logic            o_cir_r,
    output logic            o_cir_l,
    output logic            o_inc_ac,
    output logic            o_mem_ref,
    output logic            o_ind_addr,
    output logic            o_add,
    output logic            o_load,
    output logic            o_store,
    output logic            o_branch,
    output logic            o_isz,
    output logic            o_is_idle,
    output logic [SC_W-1:0] o_sc,
    output logic            o_bus_err
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic            o_illegal
`endif
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH_AR  = 4'd1;
    localparam logic [3:0] S_FETCH_IR  = 4'd2;
    localparam logic [3:0] S_DECODE    = 4'd3;
    localparam logic [3:0] S_INDIRECT  = 4'd4;
    localparam logic [3:0] S_REG       = 4'd5;
    localparam logic [3:0] S_EX_READ   = 4'd6;
    localparam logic [3:0] S_EX_FINAL  = 4'd7;
    localparam logic [3:0] S_EX_INC    = 4'd8;
    localparam logic [3:0] S_EX_WRITE  = 4'd9;
    localparam logic [3:0] S_EX_SINGLE = 4'd10;
    localparam logic [3:0] S_TRAP      = 4'd11;

    localparam logic [7:0]      TMO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [SC_W-1:0] SC_SAT   = SC_W'(7);

    logic [3:0]      state;
    logic [3:0]      state_nxt;
    logic [15:0]     ir_q;
    logic [SC_W-1:0] sc;
    logic [7:0]      tmo_cnt;
    logic            bus_err_q;
    logic [2:0]      op;
    logic            in_req;
    logic            timeout;
    logic            unused_ir_bits;

    assign op      = ir_q[14:12];
    assign in_req  = (state == S_FETCH_IR) || (state == S_INDIRECT) ||
                     (state == S_EX_READ)  || (state == S_EX_WRITE);
    assign timeout = in_req && !mem_ack && (tmo_cnt == TMO_LAST);

    // Indirect bit is consumed at decode time and the undefined ref bits
    // are only examined when the trap feature is built in.
    assign unused_ir_bits = ^{ir_q[15], ir_q[8], ir_q[4:1]};

    // First execute state for a memory-reference opcode (after any indirect fetch)
    function automatic logic [3:0] exec_entry(input logic [2:0] opc);
        case (opc)
            3'd1, 3'd2, 3'd6: exec_entry = S_EX_READ;
            3'd3:             exec_entry = S_EX_WRITE;
            3'd4:             exec_entry = S_EX_SINGLE;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:          exec_entry = S_TRAP;
`else
            default:          exec_entry = S_EX_SINGLE;
`endif
        endcase
    endfunction

    // Next-state logic: an ack always beats a coincident timeout
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_FETCH_AR;
            S_FETCH_AR:  state_nxt = S_FETCH_IR;
            S_FETCH_IR: begin
                if (mem_ack)      state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_DECODE: begin
                if ((ir[14:12] == 3'd7) && !ir[15]) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    if (ir[8] || (|ir[4:1])) state_nxt = S_TRAP;
                    else                     state_nxt = S_REG;
`else
                    state_nxt = S_REG;
`endif
                end else if (ir[15] && (ir[14:12] != 3'd7)) begin
                    state_nxt = S_INDIRECT;
                end else begin
                    state_nxt = exec_entry(ir[14:12]);
                end
            end
            S_INDIRECT: begin
                if (mem_ack)      state_nxt = exec_entry(op);
                else if (timeout) state_nxt = S_IDLE;
            end
            S_REG:       state_nxt = ir_q[0] ? S_IDLE : S_FETCH_AR;
            S_EX_READ: begin
                if (mem_ack)      state_nxt = (op == 3'd6) ? S_EX_INC : S_EX_FINAL;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_EX_FINAL:  state_nxt = S_FETCH_AR;
            S_EX_INC:    state_nxt = S_EX_WRITE;
            S_EX_WRITE: begin
                if (mem_ack)      state_nxt = S_FETCH_AR;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_EX_SINGLE: state_nxt = S_FETCH_AR;
            S_TRAP:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // State, latched instruction, step counter, timeout counter and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ir_q      <= 16'h0000;
            sc        <= '0;
            tmo_cnt   <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus_err_q <= timeout;
            if (state == S_DECODE) ir_q <= ir;
            if (in_req && (state_nxt == state)) tmo_cnt <= 8'(tmo_cnt + 8'd1);
            else                                tmo_cnt <= 8'd0;
            if ((state_nxt == S_FETCH_AR) || (state_nxt == S_IDLE)) sc <= '0;
            else if (sc != SC_SAT)                                   sc <= SC_W'(sc + 1'b1);
        end
    end

    // Moore strobe decode; only the write-ack cycle looks at mem_ack for o_clr_sc
    always_comb begin
        o_read     = 1'b0;
        o_write    = 1'b0;
        o_fetch    = 1'b0;
        o_reg_ref  = 1'b0;
        o_clr_sc   = 1'b0;
        o_clr_ac   = 1'b0;
        o_clr_e    = 1'b0;
        o_comp_ac  = 1'b0;
        o_load_ac  = 1'b0;
        o_cir_r    = 1'b0;
        o_cir_l    = 1'b0;
        o_inc_ac   = 1'b0;
        o_mem_ref  = 1'b0;
        o_ind_addr = 1'b0;
        o_add      = 1'b0;
        o_load     = 1'b0;
        o_store    = 1'b0;
        o_branch   = 1'b0;
        o_isz      = 1'b0;
        o_is_idle  = 1'b0;
        case (state)
            S_IDLE:     o_is_idle = 1'b1;
            S_FETCH_IR: begin
                o_read  = 1'b1;
                o_fetch = 1'b1;
            end
            S_INDIRECT: begin
                o_mem_ref  = 1'b1;
                o_ind_addr = 1'b1;
                o_read     = 1'b1;
            end
            S_REG: begin
                o_reg_ref = 1'b1;
                o_clr_sc  = 1'b1;
                o_clr_ac  = ir_q[11];
                o_clr_e   = ir_q[10];
                o_comp_ac = ir_q[9];
                o_cir_r   = ir_q[7];
                o_cir_l   = ir_q[6];
                o_inc_ac  = ir_q[5];
            end
            S_EX_READ: begin
                o_mem_ref = 1'b1;
                o_read    = 1'b1;
                o_add     = (op == 3'd1);
                o_load    = (op == 3'd2);
                o_isz     = (op == 3'd6);
            end
            S_EX_FINAL: begin
                o_mem_ref = 1'b1;
                o_load_ac = 1'b1;
                o_clr_sc  = 1'b1;
                o_add     = (op == 3'd1);
                o_load    = (op == 3'd2);
            end
            S_EX_INC: begin
                o_mem_ref = 1'b1;
                o_isz     = 1'b1;
            end
            S_EX_WRITE: begin
                o_mem_ref = 1'b1;
                o_write   = 1'b1;
                o_store   = (op == 3'd3);
                o_isz     = (op == 3'd6);
                o_clr_sc  = mem_ack;
            end
            S_EX_SINGLE: begin
                o_mem_ref = 1'b1;
                o_clr_sc  = 1'b1;
                o_branch  = (op == 3'd4);
            end
            default: ;
        endcase
    end

    assign o_we      = o_write;
    assign o_sc      = sc;
    assign o_bus_err = bus_err_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign o_illegal = (state == S_TRAP);
`endif

endmodule
